team_06_echo_history_buffer: RTL and testbench

Delay-line responder for the echo effect engine. It stores every saved audio sample in a circular history memory. It services "search" requests by returning the sample written `offset` samples ago on past_output with a valid strobe. It sits between the echo effect block, which drives save_audio/search/offset, and the audio sample pipeline.

---
 rtl/team_06_echo_history_buffer.sv | 150 +++++++++++++++
 tb/tb_team_06_echo_history_buffer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/team_06_echo_history_buffer.sv
// Echo history buffer: circular sample memory with offset lookback and full flush.
// Optional TEAM_06_ECHO_HIST_ZERO_FILL_EN: reads beyond fill_count return 0.
module team_06_echo_history_buffer #(
  parameter int DEPTH = 8192,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] save_audio,
  input  logic          save_valid,
  input  logic          search,
  input  logic [12:0]   offset,
  input  logic          flush,
  output logic [DW-1:0] past_output,
  output logic          past_valid,
  output logic          busy,
  output logic [AW:0]   fill_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    RESPOND,
    FLUSH
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [AW-1:0] sweep_q, sweep_d;
  logic          zero_q, zero_d;
  logic [AW:0]   fill_q, fill_d;
  logic [DW-1:0] out_q, out_d;
  logic          pv_q, pv_d;

  logic [DW-1:0] mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic [AW-1:0] off_m;
  logic          zero_hit;
  logic          accept;
  logic          save_ok;

  assign off_m = offset[AW-1:0];

`ifdef TEAM_06_ECHO_HIST_ZERO_FILL_EN
  assign zero_hit = (offset == 13'd0) || ({1'b0, off_m} > fill_q);
`else
  assign zero_hit = (offset == 13'd0);
`endif

  assign accept  = (state_q == IDLE || state_q == RESPOND)
                   && search && !flush;
  assign save_ok = (state_q != FLUSH) && save_valid && !flush;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_addr_d = rd_addr_q;
    sweep_d   = sweep_q;
    zero_d    = zero_q;
    fill_d    = fill_q;
    out_d     = out_q;
    pv_d      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_ptr_q;
    mem_wdata = save_audio;

    if (save_ok) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (fill_q != (AW+1)'(DEPTH))
        fill_d = fill_q + 1'b1;
    end

    unique case (state_q)
      IDLE, RESPOND: begin
        if (flush) begin
          state_d = FLUSH;
          sweep_d = '0;
        end else if (accept) begin
          state_d   = LOOKUP;
          rd_addr_d = wr_ptr_q - off_m;
          zero_d    = zero_hit;
        end else begin
          state_d = IDLE;
        end
      end
      LOOKUP: begin
        if (flush) begin
          state_d = FLUSH;
          sweep_d = '0;
        end else begin
          state_d = RESPOND;
          pv_d    = 1'b1;
          out_d   = zero_q ? '0 : mem[rd_addr_q];
        end
      end
      FLUSH: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_q;
        mem_wdata = '0;
        sweep_d   = sweep_q + 1'b1;
        if (sweep_q == AW'(DEPTH - 1)) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
          fill_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_addr_q <= '0;
      sweep_q   <= '0;
      zero_q    <= 1'b0;
      fill_q    <= '0;
      out_q     <= '0;
      pv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_addr_q <= rd_addr_d;
      sweep_q   <= sweep_d;
      zero_q    <= zero_d;
      fill_q    <= fill_d;
      out_q     <= out_d;
      pv_q      <= pv_d;
    end
  end

  // History contents survive reset; only a flush clears them.
  always_ff @(posedge clk) begin
    if (mem_we && !rst)
      mem[mem_waddr] <= mem_wdata;
  end

  assign past_output = out_q;
  assign past_valid  = pv_q;
  assign busy        = (state_q == LOOKUP) || (state_q == FLUSH);
  assign fill_count  = fill_q;

endmodule

// File: tb/tb_team_06_echo_history_buffer.sv
// Scoreboard bench for the echo history buffer, built with a 16-entry history.
module tb_team_06_echo_history_buffer;

  localparam int D = 16;

  logic       clk;
  logic       rst;
  logic [7:0] save_audio;
  logic       save_valid;
  logic       search;
  logic [12:0] offset;
  logic       flush;
  logic [7:0] past_output;
  logic       past_valid;
  logic       busy;
  logic [4:0] fill_count;

  team_06_echo_history_buffer #(.DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .save_audio (save_audio),
    .save_valid (save_valid),
    .search     (search),
    .offset     (offset),
    .flush      (flush),
    .past_output(past_output),
    .past_valid (past_valid),
    .busy       (busy),
    .fill_count (fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int expq[$];
  int mmem[D];
  int mwp;
  int mfill;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic int expv(input int off);
    int om;
    om = off % D;
    if (off == 0) return 0;
`ifdef TEAM_06_ECHO_HIST_ZERO_FILL_EN
    if (om > mfill) return 0;
`endif
    return mmem[(mwp - om + D) % D];
  endfunction

  task automatic mwrite(input int v);
    mmem[mwp] = v;
    mwp = (mwp + 1) % D;
    if (mfill < D) mfill++;
  endtask

  task automatic save(input int v);
    save_valid = 1'b1;
    save_audio = 8'(v);
    mwrite(v);
    cyc();
    save_valid = 1'b0;
  endtask

  task automatic srch(input int off);
    search = 1'b1;
    offset = 13'(off);
    expq.push_back(expv(off));
    cyc();
    search = 1'b0;
    chk("pv_early", past_valid, 0);
    cyc();
    chk("pv_lat", past_valid, 1);
    cyc();
  endtask

  task automatic save_srch(input int v, input int off);
    expq.push_back(expv(off));
    mwrite(v);
    save_valid = 1'b1;
    save_audio = 8'(v);
    search     = 1'b1;
    offset     = 13'(off);
    cyc();
    save_valid = 1'b0;
    search     = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic do_flush();
    int n;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      if (n == 3) begin
        flush      = 1'b1;
        save_valid = 1'b1;
        save_audio = 8'hAA;
      end else begin
        flush      = 1'b0;
        save_valid = 1'b0;
      end
      n++;
      cyc();
    end
    flush      = 1'b0;
    save_valid = 1'b0;
    chk("flush_len", n, D);
    for (int i = 0; i < D; i++) mmem[i] = 0;
    mwp   = 0;
    mfill = 0;
    chk("fill_after_flush", fill_count, 0);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    mwp   = 0;
    mfill = 0;
  endtask

  // Every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (past_valid) begin
      if (expq.size() == 0)
        chk("spurious_valid", 1, 0);
      else
        chk("past_output", past_output, expq.pop_front());
    end
  end

  initial begin
    rst        = 1'b1;
    save_audio = '0;
    save_valid = 1'b0;
    search     = 1'b0;
    offset     = '0;
    flush      = 1'b0;
    mwp        = 0;
    mfill      = 0;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_out", past_output, 0);
    chk("rst_pv", past_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fill", fill_count, 0);

    do_flush();

    do_rst();
    save(68);
    save(78);
    save(75);
    srch(1);
    srch(3);
    chk("fill3", fill_count, 3);

    do_rst();
    save(50);
    save(89);
    srch(5);
    srch(0);
    srch(2);

    save(56);
    save_srch(99, 1);
    srch(1);

    do_flush();
    for (int v = 0; v < 20; v++) save(v);
    chk("fill_sat", fill_count, D);
    srch(1);
    srch(15);
    srch(17);

    // Level search: accepted, ignored in LOOKUP, accepted again in RESPOND.
    search = 1'b1;
    offset = 13'd1;
    expq.push_back(expv(1));
    cyc();
    offset = 13'd7;
    cyc();
    offset = 13'd2;
    expq.push_back(expv(2));
    cyc();
    search = 1'b0;
    cyc();
    cyc();

    search = 1'b1;
    offset = 13'd1;
    cyc();
    search = 1'b0;
    do_flush();
    srch(1);

    save(33);
    search = 1'b1;
    offset = 13'd1;
    cyc();
    search = 1'b0;
    chk("lookup_busy", busy, 1);
    rst = 1'b1;
    cyc();
    rst   = 1'b0;
    mwp   = 0;
    mfill = 0;
    chk("rst6_pv", past_valid, 0);
    chk("rst6_out", past_output, 0);
    chk("rst6_busy", busy, 0);
    chk("rst6_fill", fill_count, 0);
    cyc();
    cyc();
    save(65);
    srch(1);

    cyc();
    cyc();
    cyc();
    chk("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
